// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: FSM state encoding and
// the rest code that silences the output.
package note_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int unsigned REST = 0;

endpackage

// File: rtl/note_tone_gen.sv
// Free-running square-wave channel: each level lasts period+1 cycles, and a
// zero period parks the output low.
module note_tone_gen #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  output logic                tone
);

  logic [PERIOD_W-1:0] cnt;

  // Period is sampled only on reload, so a change lands at the next toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (period == '0) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= period;
      tone <= ~tone;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Queued note player: accepts (note, duration) commands into a small FIFO and
// routes the selected tone channel to the output for each note's duration.
module note_sequencer #(
  parameter int NUM_NOTES = 7,
  parameter int PERIOD_W  = 8,
  parameter int DUR_W     = 16,
  parameter int DEPTH     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NOTES*PERIOD_W-1:0]     note_periods,
  input  logic                              cmd_val,
  output logic                              cmd_rdy,
  input  logic [$clog2(NUM_NOTES+1)-1:0]    cmd_note,
  input  logic [DUR_W-1:0]                  cmd_duration,
  input  logic                              stop,
  output logic [$clog2(NUM_NOTES+1)-1:0]    note_sel,
  output logic                              note,
  output logic                              play_done,
  output logic                              busy,
  output logic [$clog2(DEPTH+1)-1:0]        q_count
);

  import note_seq_pkg::*;

  localparam int SEL_W = $clog2(NUM_NOTES + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  function automatic logic [DUR_W-1:0] dur_floor(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  logic [NUM_NOTES-1:0] tones;

  genvar k;
  generate
    for (k = 0; k < NUM_NOTES; k++) begin : g_ch
      note_tone_gen #(
        .PERIOD_W(PERIOD_W)
      ) u_tone (
        .clk   (clk),
        .rst   (rst),
        .period(note_periods[k*PERIOD_W +: PERIOD_W]),
        .tone  (tones[k])
      );
    end
  endgenerate

  logic [SEL_W-1:0] q_note [DEPTH];
  logic [DUR_W-1:0] q_dur  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;
  logic [DUR_W-1:0] dur_cnt;
  logic             last;
  logic             push;
  logic             pop;

  assign last    = (state == PLAY) && (dur_cnt <= DUR_W'(1));
  assign cmd_rdy = !rst && !stop && (count < CNT_W'(DEPTH));
  assign push    = cmd_val && cmd_rdy;
  // Pop either from idle or in the final cycle of a note, so notes chain gap-free.
  assign pop     = !stop && (count != '0) && ((state == IDLE) || last);

  always_ff @(posedge clk) begin
    if (push) begin
      q_note[wr_ptr] <= cmd_note;
      q_dur[wr_ptr]  <= cmd_duration;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      state    <= IDLE;
      note_sel <= SEL_W'(REST);
      dur_cnt  <= '0;
    end else if (pop) begin
      state    <= PLAY;
      note_sel <= q_note[rd_ptr];
      dur_cnt  <= dur_floor(q_dur[rd_ptr]);
    end else if (last) begin
      state    <= IDLE;
      note_sel <= SEL_W'(REST);
      dur_cnt  <= '0;
    end else if (state == PLAY) begin
      dur_cnt <= dur_cnt - 1'b1;
    end
  end

  // Codes outside 1..NUM_NOTES match no channel and fall through to silence.
  always_comb begin
    note = 1'b0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (note_sel == SEL_W'(i + 1)) note = tones[i];
    end
    if (rst) note = 1'b0;
  end

  assign play_done = last && !stop && !rst;
  assign busy      = !rst && ((state == PLAY) || (count != '0));
  assign q_count   = rst ? '0 : count;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with hand-computed expectations.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [55:0] note_periods;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [2:0]  cmd_note;
  logic [15:0] cmd_duration;
  logic        stop;
  logic [2:0]  note_sel;
  logic        note;
  logic        play_done;
  logic        busy;
  logic [2:0]  q_count;

  int total = 0;
  int bad   = 0;
  int es[$];
  int ed[$];

  note_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .note_periods(note_periods),
    .cmd_val     (cmd_val),
    .cmd_rdy     (cmd_rdy),
    .cmd_note    (cmd_note),
    .cmd_duration(cmd_duration),
    .stop        (stop),
    .note_sel    (note_sel),
    .note        (note),
    .play_done   (play_done),
    .busy        (busy),
    .q_count     (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_cmd(input int n, input int d);
    cmd_val      = 1'b1;
    cmd_note     = 3'(n);
    cmd_duration = 16'(d);
    tick();
    cmd_val = 1'b0;
  endtask

  task automatic add_note(input int n, input int len);
    for (int i = 0; i < len; i++) begin
      es.push_back(n);
      ed.push_back((i == len - 1) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] pat;
    logic        prev;
    bit          found;

    rst          = 1'b1;
    cmd_val      = 1'b0;
    cmd_note     = '0;
    cmd_duration = '0;
    stop         = 1'b0;
    note_periods = {8'd3, 8'd3, 8'd3, 8'd3, 8'd1, 8'd0, 8'd2};

    tick();
    tick();
    chk("rst_note", note, 0);
    chk("rst_done", play_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_qcnt", q_count, 0);
    chk("rst_rdy", cmd_rdy, 0);
    chk("rst_sel", note_sel, 0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", cmd_rdy, 1);

    // single note into an idle block
    push_cmd(3, 5);
    chk("n3_qcnt", q_count, 1);
    chk("n3_sel_pre", note_sel, 0);
    chk("n3_busy_pre", busy, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("n3_sel", note_sel, 3);
      chk("n3_done", play_done, (i == 4) ? 1 : 0);
      tick();
    end
    chk("n3_end_sel", note_sel, 0);
    chk("n3_end_busy", busy, 0);
    chk("n3_end_done", play_done, 0);

    // zero duration and rest, with push and pop on the same edge
    push_cmd(5, 0);
    chk("z_q1", q_count, 1);
    cmd_val = 1'b1; cmd_note = 3'd0; cmd_duration = 16'd0;
    tick();
    chk("z_sel5", note_sel, 5);
    chk("z_done5", play_done, 1);
    chk("z_qpp1", q_count, 1);
    cmd_note = 3'd4; cmd_duration = 16'd1;
    tick();
    cmd_val = 1'b0;
    chk("z_sel_rest", note_sel, 0);
    chk("z_note_rest", note, 0);
    chk("z_done_rest", play_done, 1);
    chk("z_busy_rest", busy, 1);
    chk("z_qpp2", q_count, 1);
    tick();
    chk("z_sel4", note_sel, 4);
    chk("z_done4", play_done, 1);
    chk("z_q0", q_count, 0);
    tick();
    chk("z_end_sel", note_sel, 0);
    chk("z_end_busy", busy, 0);
    chk("z_end_done", play_done, 0);

    // fill the queue while a long note plays, then drain gap-free
    push_cmd(1, 10);
    tick();
    chk("f_a1", note_sel, 1);
    push_cmd(2, 2); chk("f_q1", q_count, 1);
    push_cmd(4, 3); chk("f_q2", q_count, 2);
    push_cmd(5, 1); chk("f_q3", q_count, 3);
    push_cmd(6, 2); chk("f_q4", q_count, 4);
    cmd_val = 1'b1; cmd_note = 3'd7; cmd_duration = 16'd1;
    #1;
    chk("f_rdy_full", cmd_rdy, 0);
    tick();
    cmd_val = 1'b0;
    chk("f_q4_hold", q_count, 4);
    add_note(1, 5);
    add_note(2, 2);
    add_note(4, 3);
    add_note(5, 1);
    add_note(6, 2);
    for (int i = 0; i < es.size(); i++) begin
      chk($sformatf("f_sel%0d", i), note_sel, es[i]);
      chk($sformatf("f_done%0d", i), play_done, ed[i]);
      tick();
    end
    chk("f_end_sel", note_sel, 0);
    chk("f_end_busy", busy, 0);

    // note 1 tone, half-period 2: three cycles per level
    push_cmd(1, 40);
    tick();
    chk("t_sel", note_sel, 1);
    found = 1'b0;
    prev  = note;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (note && !prev) found = 1'b1;
      else prev = note;
    end
    chk("t_edge", found, 1);
    pat = 12'b111000111000;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t_pat%0d", i), note, pat[11-i]);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t_stop_sel", note_sel, 0);
    chk("t_stop_busy", busy, 0);

    // zero-period channel stays silent
    push_cmd(2, 6);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("p0_sel", note_sel, 2);
      chk("p0_note", note, 0);
      tick();
    end
    chk("p0_end", note_sel, 0);

    // stop mid-note with two queued and a command offered
    push_cmd(3, 10);
    tick();
    push_cmd(4, 5);
    push_cmd(5, 5);
    chk("s_q2", q_count, 2);
    stop = 1'b1; cmd_val = 1'b1; cmd_note = 3'd6; cmd_duration = 16'd3;
    #1;
    chk("s_rdy", cmd_rdy, 0);
    tick();
    chk("s_q0", q_count, 0);
    chk("s_sel", note_sel, 0);
    chk("s_busy", busy, 0);
    chk("s_done", play_done, 0);
    stop = 1'b0; cmd_val = 1'b0;
    tick();
    chk("s_drop_sel", note_sel, 0);
    chk("s_drop_busy", busy, 0);

    // stop in the last cycle suppresses play_done
    push_cmd(3, 2);
    tick();
    tick();
    chk("sl_done_pre", play_done, 1);
    stop = 1'b1;
    #1;
    chk("sl_done_stop", play_done, 0);
    tick();
    stop = 1'b0;
    chk("sl_sel", note_sel, 0);
    chk("sl_busy", busy, 0);

    // reset mid-play, then normal operation
    push_cmd(4, 8);
    tick();
    push_cmd(5, 3);
    chk("r_busy_pre", busy, 1);
    chk("r_q_pre", q_count, 1);
    rst = 1'b1;
    tick();
    chk("r_sel", note_sel, 0);
    chk("r_note", note, 0);
    chk("r_done", play_done, 0);
    chk("r_busy", busy, 0);
    chk("r_q", q_count, 0);
    chk("r_rdy", cmd_rdy, 0);
    rst = 1'b0;
    push_cmd(3, 2);
    tick();
    chk("r_n1_sel", note_sel, 3);
    chk("r_n1_done", play_done, 0);
    tick();
    chk("r_n2_sel", note_sel, 3);
    chk("r_n2_done", play_done, 1);
    tick();
    chk("r_end_sel", note_sel, 0);
    chk("r_end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
